// File: rtl/alu_pkg.sv
// Definitions shared by the ALU, its decoder and the result stage:
// op codes, NZCV bit positions, the buffered result entry and skid buffer states.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_TAG_W  = 5;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOR  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_XNOR = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_CMP  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_LAST = OP_ROR;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] y;
        logic [3:0]            op;
        logic                  carry;
        logic                  ovf;
        logic [ALU_TAG_W-1:0]  rd;
        logic                  set_flags;
    } alu_result_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready_o is a flop so the
// upstream path never sees a combinational dependency on out_ready_i.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    skid_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 in_ready_q;
    logic                 accept, retire;

    assign accept      = in_valid_i & in_ready_q;
    assign retire      = out_valid_o & out_ready_i;
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = main_q;
    assign in_ready_o  = in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    main_d  = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && retire) begin
                    main_d = in_data_i;
                end else if (accept) begin
                    skid_d  = in_data_i;
                    state_d = SKID_FULL;
                end else if (retire) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (retire) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SKID_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != SKID_FULL);
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: skid-buffers results and, on retire,
// commits NZCV for flag-setting ops and bumps the retire counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned TAG_W  = ALU_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_y,
    input  logic [3:0]        in_op,
    input  logic              in_carry,
    input  logic              in_ovf,
    input  logic [TAG_W-1:0]  in_rd,
    input  logic              in_set_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [TAG_W-1:0]  out_rd,
    output logic [3:0]        nzcv,
    output logic [31:0]       retire_cnt
);

    alu_result_t in_entry, main_entry;
    logic        retire;
    logic [3:0]  nzcv_q, nzcv_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    assign in_entry = '{y: in_y, op: in_op, carry: in_carry, ovf: in_ovf,
                        rd: in_rd, set_flags: in_set_flags};

    alu_skid_buf #(
        .PAYLOAD_W ($bits(alu_result_t))
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (main_entry)
    );

    assign retire = out_valid & out_ready;
    assign out_y  = main_entry.y;
    assign out_rd = main_entry.rd;

    // Op codes beyond the ALU's range still retire but leave NZCV alone.
    always_comb begin
        nzcv_d = nzcv_q;
        if (retire && main_entry.set_flags && (main_entry.op <= OP_LAST)) begin
            nzcv_d[NZCV_N] = main_entry.y[DATA_W-1];
            nzcv_d[NZCV_Z] = (main_entry.y == '0);
            if ((main_entry.op == OP_ADD) || (main_entry.op == OP_SUB)) begin
                nzcv_d[NZCV_C] = main_entry.carry;
                nzcv_d[NZCV_V] = main_entry.ovf;
            end
        end
    end

    assign retire_cnt_d = retire_cnt_q + 32'(retire);

    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            nzcv_q       <= nzcv_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign nzcv       = nzcv_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, flag commit, backpressure,
// randomised streaming against a queue model, counter wrap and reset in FULL.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_y;
    logic [3:0]  in_op;
    logic        in_carry, in_ovf;
    logic [4:0]  in_rd;
    logic        in_set_flags;
    logic        out_valid, out_ready;
    logic [31:0] out_y;
    logic [4:0]  out_rd;
    logic [3:0]  nzcv;
    logic [31:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_stage #(
        .DATA_W (32),
        .TAG_W  (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_y         (in_y),
        .in_op        (in_op),
        .in_carry     (in_carry),
        .in_ovf       (in_ovf),
        .in_rd        (in_rd),
        .in_set_flags (in_set_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_rd       (out_rd),
        .nzcv         (nzcv),
        .retire_cnt   (retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] y, input logic [3:0] op, input logic c,
                         input logic v, input logic [4:0] rd, input logic sf);
        in_y = y; in_op = op; in_carry = c; in_ovf = v; in_rd = rd; in_set_flags = sf;
        in_valid = 1'b1;
    endtask

    // Single result through an idle stage with out_ready high: accept, then retire.
    task automatic send_one(input logic [31:0] y, input logic [3:0] op, input logic c,
                            input logic v, input logic sf);
        drive(y, op, c, v, 5'd9, sf);
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
    endtask

    initial begin
        logic [36:0] exp_q[$];
        logic [36:0] front;
        int          sent, got, occ;
        logic        pending, acc, ret;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_y = 32'h1234_5678; in_op = OP_ADD; in_carry = 1'b1; in_ovf = 1'b1;
        in_rd = 5'd3; in_set_flags = 1'b1;

        // Reset with in_valid held high
        tick;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_nzcv", nzcv, 4'b0000);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        tick;
        rst = 1'b0; in_valid = 1'b0;
        tick;
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Add with carry, zero result
        drive(32'h0000_0000, OP_ADD, 1'b1, 1'b0, 5'd7, 1'b1);
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("add_out_valid", out_valid, 1'b1);
        chk("add_out_y", out_y, 32'h0);
        chk("add_out_rd", out_rd, 5'd7);
        tick;
        chk("add_nzcv", nzcv, 4'b0110);
        chk("add_cnt", retire_cnt, 32'd1);
        chk("add_drained", out_valid, 1'b0);

        // Logical op keeps C/V
        send_one(32'h0000_0005, OP_ADD, 1'b1, 1'b1, 1'b1);
        chk("setup_nzcv", nzcv, 4'b0011);
        send_one(32'h8000_0000, OP_XOR, 1'b0, 1'b0, 1'b1);
        chk("xor_nzcv", nzcv, 4'b1011);
        send_one(32'h0000_0000, 4'd13, 1'b0, 1'b0, 1'b1);
        chk("op13_nzcv", nzcv, 4'b1011);
        send_one(32'h0000_0000, OP_SUB, 1'b0, 1'b0, 1'b0);
        chk("noflags_nzcv", nzcv, 4'b1011);
        chk("op13_cnt", retire_cnt, 32'd5);

        // Backpressure: A, B accepted, C stalled
        rst = 1'b1; out_ready = 1'b0; tick; rst = 1'b0;
        drive(32'hAAAA_0001, OP_OR, 1'b0, 1'b0, 5'd1, 1'b0);
        tick;
        chk("bp_ready_after_a", in_ready, 1'b1);
        chk("bp_out_a0", out_y, 32'hAAAA_0001);
        drive(32'hBBBB_0002, OP_OR, 1'b0, 1'b0, 5'd2, 1'b0);
        tick;
        chk("bp_ready_drop", in_ready, 1'b0);
        chk("bp_out_a1", out_y, 32'hAAAA_0001);
        drive(32'hCCCC_0003, OP_OR, 1'b0, 1'b0, 5'd3, 1'b0);
        tick;
        chk("bp_c_stalled", in_ready, 1'b0);
        chk("bp_out_a2", out_y, 32'hAAAA_0001);
        chk("bp_rd_a", out_rd, 5'd1);
        out_ready = 1'b1;
        tick;
        chk("bp_out_b", out_y, 32'hBBBB_0002);
        chk("bp_ready_back", in_ready, 1'b1);
        tick;
        in_valid = 1'b0;
        chk("bp_out_c", out_y, 32'hCCCC_0003);
        chk("bp_rd_c", out_rd, 5'd3);
        tick;
        chk("bp_empty", out_valid, 1'b0);
        chk("bp_cnt", retire_cnt, 32'd3);

        // Streaming with random out_ready, checked against a FIFO model
        sent = 0; got = 0; pending = 1'b0;
        for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
            if (!pending) begin
                if (sent < 100) begin
                    drive($urandom, 4'($urandom_range(0, 12)), 1'b0, 1'b0, 5'(sent), 1'b0);
                    pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            occ = sent - got;
            chk("stream_in_ready", in_ready, (occ < 2));
            chk("stream_out_valid", out_valid, (occ > 0));
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious", {out_rd, out_y}, 37'h0);
                end else begin
                    front = exp_q.pop_front();
                    chk("stream_data", {out_rd, out_y}, front);
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back({in_rd, in_y});
                sent++;
            end
            tick;
            if (acc) pending = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_got", got, 100);
        chk("stream_cnt", retire_cnt, 32'd103);

        // Counter wrap
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        send_one(32'h0000_0001, OP_AND, 1'b0, 1'b0, 1'b0);
        chk("cnt_wrap", retire_cnt, 32'd0);

        // Reset while FULL drops both entries
        out_ready = 1'b0;
        drive(32'h1111_1111, OP_OR, 1'b0, 1'b0, 5'd4, 1'b1);
        tick;
        drive(32'h2222_2222, OP_OR, 1'b0, 1'b0, 5'd5, 1'b1);
        tick;
        chk("full_in_ready", in_ready, 1'b0);
        rst = 1'b1; in_valid = 1'b0;
        tick;
        chk("full_rst_out_valid", out_valid, 1'b0);
        chk("full_rst_in_ready", in_ready, 1'b1);
        chk("full_rst_out_y", out_y, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick;
        tick;
        chk("full_rst_no_retire", out_valid, 1'b0);
        chk("full_rst_cnt", retire_cnt, 32'd0);
        chk("full_rst_nzcv", nzcv, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the 32-bit ALU. Captures each ALU result (`y`, carry/neg/zero/overflow) with its destination tag through a valid/ready handshake. Buffers it in a 2-entry skid buffer so the ALU path never sees a combinational `ready`. Commits the NZCV status register and a retire counter when a result leaves toward writeback.

## Interface
- `DATA_W`, 32, result width; `y` and `out_y`.
- `TAG_W`, 5, destination-register tag width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ALU result present.
- `in_ready`  out  1  stage can accept; registered.
- `in_y`  in  DATA_W  ALU result.
- `in_op`  in  4  ALU control code that produced `in_y` (0–12).
- `in_carry`, `in_ovf`  in  1 each  ALU carry and overflow flags.
- `in_rd`  in  TAG_W  destination tag.
- `in_set_flags`  in  1  result updates NZCV on retire.
- `out_valid`  out  1  result available to writeback.
- `out_ready`  in  1  writeback accepts.
- `out_y`  out  DATA_W  held result.
- `out_rd`  out  TAG_W  held tag.
- `nzcv`  out  4  status register {N,Z,C,V}.
- `retire_cnt`  out  32  count of retired results.

## Operation
- **Accept and retire.**
  - Accept when `in_valid & in_ready`.
  - Retire when `out_valid & out_ready`.
- **Storage.**
  - Main register: drives `out_*`.
  - Skid register: one entry.
  - Each entry holds y, op, carry, ovf, rd, set_flags.
- **Buffer states.**
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: main valid, skid empty, `in_ready`=1.
  - FULL: main and skid valid, `in_ready`=0.
- **Buffer transitions.**
  - EMPTY + accept → ONE.
  - ONE + accept, no retire → FULL; new entry goes to skid.
  - ONE + accept + retire → ONE; main reloads from input.
  - ONE + retire, no accept → EMPTY.
  - FULL + retire → ONE; skid moves to main.
  - No accept in FULL, since `in_ready`=0.
- **Ordering and throughput.**
  - Strict FIFO order.
  - Sustained 1 result/cycle when `out_ready` is held high.
- **Flag computation at retire, when main `set_flags`=1.**
  - N = y[DATA_W-1] and Z = (y==0), computed locally for all ops.
  - Ops 6 (add) and 7 (sub): C = carry, V = ovf.
  - All other ops: C and V retained.
  - Ops ≥13: no NZCV update, but still retire and count.
  - `set_flags`=0: NZCV unchanged.
- **Retire counter.** `retire_cnt` += 1 per retire, wrapping 0xFFFF_FFFF → 0.

## Timing
- **Reset values.** `rst` at the clock edge gives:
  - `in_ready`=1, `out_valid`=0, `out_y`=0, `out_rd`=0.
  - `nzcv`=4'b0000, `retire_cnt`=0.
  - Skid invalidated.
- **Reset mid-operation.** Held entries are discarded and never retired.
- **Latency.** Accept at edge k → `out_valid`=1 after edge k when main was empty or retiring at k.
- **Ready timing.** `in_ready` is a pure register: high after any edge where skid is empty. Asserted again the cycle after FULL retires.
- **NZCV and counter.** Both update on the retire edge; the new value is visible the following cycle.
- **Simultaneous accept and retire in ONE.** Main takes the input, the retiring entry updates flags and counter, and there is no bubble.
- **Output stability.** While `out_valid`=1 and `out_ready`=0, `out_y` and `out_rd` hold stable (no X, no change).
- **Upstream rule.** Upstream must hold `in_*` stable while `in_valid`=1 and `in_ready`=0. The stage does not check this.

## Structure
- **Shared `alu_pkg`.**
  - ALU op-code localparams: OP_OR=0 … OP_ADD=6, OP_SUB=7, OP_SHL=8, OP_SHR=9, OP_CMP=10, OP_ROL=11, OP_ROR=12.
  - NZCV bit indices.
  - Result-entry packed struct.
  - The ALU and its decoder use the same op codes.
- **Sub-module `alu_skid_buf`.** Generic 2-entry valid/ready skid buffer, parameterised by payload width.
- **Remaining logic.** Flag/NZCV commit and the counter stay in `alu_result_stage`.

## Test plan
- **Reset.** Apply reset with `in_valid`=1 held → `out_valid`=0, `in_ready`=1, `nzcv`=0, `retire_cnt`=0 during and after reset.
- **Add with carry and flag set.** Single add: `in_y`=0x0000_0000, `in_op`=6, `in_carry`=1, `in_ovf`=0, `in_set_flags`=1, `out_ready`=1.
  - Result next cycle with `out_y`=0.
  - After retire, `nzcv`=4'b0110 and `retire_cnt`=1.
- **Logical op retains C/V.** With `nzcv`=4'b0011, retire XOR (op 5) with y=0x8000_0000 and set_flags=1 → `nzcv`=4'b1011.
- **Backpressure.** `out_ready`=0, offer 3 results A,B,C.
  - A and B are accepted; `in_ready` drops after B; C is stalled.
  - `out_y` stays A.
  - Raise `out_ready` → A,B,C retire in order with `retire_cnt`=3.
- **Streaming.** 100 back-to-back results with random `out_ready`.
  - Scoreboard sees order and data exact, with no loss or duplication.
  - `in_ready` never depends combinationally on `out_ready`.
- **Counter wrap and reset.**
  - Force `retire_cnt`=0xFFFF_FFFF, retire one → 0.
  - Assert `rst` in FULL state → both entries dropped and `out_valid`=0 the next cycle.
